// File: rtl/removal_sequencer.sv
// -----------------------------------------------------------------------------
// removal_sequencer
//
// Iterative controller around a single-sweep combinational removal unit.
// Owns the grid register file and loads it one row per accepted handshake.
// On start it applies one removal sweep per clock. It stops when a sweep
// removes nothing or when the pass limit is reached. It reports the total
// number of cells removed, the first-sweep count and the number of
// productive passes.
//
// A cell (1 = paper) is removed by a sweep when fewer than four of its eight
// neighbours hold paper. Cells outside the grid count as empty. Every cell in
// a sweep is judged against the same pre-sweep grid.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   load_valid     load_row valid
//   load_row       grid row, bit c = column c; rows arrive in order 0..DEPTH-1
//   load_ready     row accepted when load_valid & load_ready
//   start          run request (level, sampled in IDLE)
//   busy           high while sweeping
//   done           one-cycle pulse at end of run
//   limit_hit      run ended at MAX_PASSES with removals still occurring
//   total_removed  sum of removals over all passes
//   first_removed  removals in pass 1
//   pass_count     passes that removed at least one cell
//   rd_addr        row select for read-back
//   rd_row         grid[rd_addr], combinational
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | accept rows into the grid; wait for start with a loaded grid
// RUN   | one sweep per clock until nothing is removed or limit reached
// DONE  | single-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module removal_sequencer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int MAX_PASSES = 256,
    localparam int CNT_W     = $clog2(WIDTH * DEPTH + 1),
    localparam int PASS_W    = $clog2(MAX_PASSES + 1),
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_row,
    output logic              load_ready,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              limit_hit,
    output logic [CNT_W-1:0]  total_removed,
    output logic [CNT_W-1:0]  first_removed,
    output logic [PASS_W-1:0] pass_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_row
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   grid  [DEPTH];
    logic [WIDTH-1:0]   swept [DEPTH];
    logic [ADDR_W-1:0]  row_ptr;
    logic               grid_loaded;
    logic               first_pass;

    // Grid surrounded by a ring of empty cells so edge cells need no special
    // casing in the neighbour count.
    logic [WIDTH+1:0]       pad [DEPTH+2];
    logic [WIDTH*DEPTH-1:0] kill;
    logic [CNT_W-1:0]       removed;

    assign pad[0]       = '0;
    assign pad[DEPTH+1] = '0;

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        assign pad[r+1] = {1'b0, grid[r], 1'b0};

        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [3:0] nbr;

            // Cell (r,c) sits at pad[r+1][c+1]; its neighbours span
            // pad rows r..r+2 and pad columns c..c+2.
            assign nbr = 4'(pad[r][c])     + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                       + 4'(pad[r+1][c])                       + 4'(pad[r+1][c+2])
                       + 4'(pad[r+2][c])   + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);

            assign kill[r*WIDTH+c] = grid[r][c] & (nbr < 4'd4);
        end

        assign swept[r] = grid[r] & ~kill[r*WIDTH +: WIDTH];
    end

    always_comb begin
        removed = '0;
        for (int i = 0; i < WIDTH * DEPTH; i++) begin
            removed = removed + CNT_W'(kill[i]);
        end
    end

    // Start outranks a simultaneous row, so the grid cannot change under a
    // run that is just being launched.
    assign load_ready = (state == IDLE) && !(start && grid_loaded);
    assign rd_row     = grid[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                grid[i] <= '0;
            end
            row_ptr       <= '0;
            grid_loaded   <= 1'b0;
            first_pass    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            limit_hit     <= 1'b0;
            total_removed <= '0;
            first_removed <= '0;
            pass_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && grid_loaded) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        first_pass    <= 1'b1;
                        total_removed <= '0;
                        first_removed <= '0;
                        pass_count    <= '0;
                        limit_hit     <= 1'b0;
                    end else if (load_valid) begin
                        grid[row_ptr] <= load_row;
                        if (row_ptr == ADDR_W'(DEPTH - 1)) begin
                            row_ptr     <= '0;
                            grid_loaded <= 1'b1;
                        end else begin
                            row_ptr <= row_ptr + ADDR_W'(1);
                        end
                    end
                end

                RUN: begin
                    first_pass <= 1'b0;
                    if (first_pass) begin
                        first_removed <= removed;
                    end
                    if (removed != '0) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            grid[i] <= swept[i];
                        end
                        total_removed <= total_removed + removed;
                        pass_count    <= pass_count + PASS_W'(1);
                        if (pass_count + PASS_W'(1) == PASS_W'(MAX_PASSES)) begin
                            limit_hit <= 1'b1;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_removal_sequencer.sv
module tb_removal_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid = 1'b0;
    logic [3:0] load_row   = 4'd0;
    logic       start      = 1'b0;
    logic [1:0] rd_addr    = 2'd0;

    // instance 0: MAX_PASSES=256, instance 1: MAX_PASSES=2
    logic       lr0, busy0, done0, lim0;
    logic [4:0] tot0, fst0;
    logic [8:0] pc0;
    logic [3:0] row0;
    logic       lr1, busy1, done1, lim1;
    logic [4:0] tot1, fst1;
    logic [1:0] pc1;
    logic [3:0] row1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    removal_sequencer #(.WIDTH(4), .DEPTH(4), .MAX_PASSES(256)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_row(load_row),
        .load_ready(lr0), .start(start), .busy(busy0), .done(done0),
        .limit_hit(lim0), .total_removed(tot0), .first_removed(fst0),
        .pass_count(pc0), .rd_addr(rd_addr), .rd_row(row0)
    );

    removal_sequencer #(.WIDTH(4), .DEPTH(4), .MAX_PASSES(2)) dut_lim (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_row(load_row),
        .load_ready(lr1), .start(start), .busy(busy1), .done(done1),
        .limit_hit(lim1), .total_removed(tot1), .first_removed(fst1),
        .pass_count(pc1), .rd_addr(rd_addr), .rd_row(row1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Grid held as 16 bits, cell (r,c) at bit r*4+c.
    int          m_phase  [2];   // 0 idle, 1 sweeping, 2 done pulse
    int          m_left   [2];
    int          m_loaded [2];
    int          m_ptr    [2];
    int          m_first  [2];
    int          m_total  [2];
    int          m_pass   [2];
    int          m_lim    [2];
    logic [15:0] m_grid   [2];
    int          maxp     [2] = '{256, 2};

    function automatic logic [15:0] sweep(input logic [15:0] g, output int n);
        logic [15:0] o;
        int cnt;
        n = 0;
        o = g;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (g[r*4+c]) begin
                    cnt = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 4 &&
                                c+dc >= 0 && c+dc < 4 && g[(r+dr)*4+(c+dc)])
                                cnt++;
                        end
                    end
                    if (cnt < 4) begin
                        o[r*4+c] = 1'b0;
                        n++;
                    end
                end
            end
        end
        return o;
    endfunction

    task automatic model_run(input int k);
        logic [15:0] g;
        int n;
        bit  stop;
        g = m_grid[k];
        m_total[k] = 0;
        m_pass[k]  = 0;
        m_lim[k]   = 0;
        g = sweep(g, n);
        m_first[k] = n;
        stop = (n == 0);
        while (!stop) begin
            m_grid[k]  = g;
            m_total[k] += n;
            m_pass[k]++;
            if (m_pass[k] == maxp[k]) begin
                m_lim[k] = 1;
                stop = 1;
            end else begin
                g = sweep(g, n);
                stop = (n == 0);
            end
        end
        // busy cycles: one per productive pass, plus the empty sweep unless the limit ended it
        m_left[k] = m_lim[k] ? m_pass[k] : m_pass[k] + 1;
    endtask

    task automatic model_reset(input int k);
        m_phase[k] = 0; m_left[k] = 0; m_loaded[k] = 0; m_ptr[k] = 0;
        m_first[k] = 0; m_total[k] = 0; m_pass[k] = 0; m_lim[k] = 0;
        m_grid[k] = '0;
    endtask

    task automatic cmp_step(input int k);
        logic a_lr, a_busy, a_done, a_lim;
        int   a_tot, a_fst, a_pc;
        logic [3:0] a_row;
        if (k == 0) begin
            a_lr = lr0; a_busy = busy0; a_done = done0; a_lim = lim0;
            a_tot = int'(tot0); a_fst = int'(fst0); a_pc = int'(pc0); a_row = row0;
        end else begin
            a_lr = lr1; a_busy = busy1; a_done = done1; a_lim = lim1;
            a_tot = int'(tot1); a_fst = int'(fst1); a_pc = int'(pc1); a_row = row1;
        end
        if (rst) model_reset(k);
        chk($sformatf("i%0d_load_ready", k), a_lr, (m_phase[k] == 0) && !(start && m_loaded[k] != 0));
        chk($sformatf("i%0d_busy", k), a_busy, m_phase[k] == 1);
        chk($sformatf("i%0d_done", k), a_done, m_phase[k] == 2);
        if (m_phase[k] != 1) begin
            chk($sformatf("i%0d_limit_hit", k), a_lim, m_lim[k]);
            chk($sformatf("i%0d_total", k), a_tot, m_total[k]);
            chk($sformatf("i%0d_first", k), a_fst, m_first[k]);
            chk($sformatf("i%0d_pass", k), a_pc, m_pass[k]);
            chk($sformatf("i%0d_rd_row%0d", k, rd_addr), a_row, m_grid[k][rd_addr*4 +: 4]);
        end
        if (rst) return;
        // advance to the state expected after the coming rising edge
        case (m_phase[k])
            0: begin
                if (start && m_loaded[k] != 0) begin
                    model_run(k);
                    m_phase[k] = 1;
                end else if (load_valid) begin
                    m_grid[k][m_ptr[k]*4 +: 4] = load_row;
                    if (m_ptr[k] == 3) begin
                        m_ptr[k] = 0;
                        m_loaded[k] = 1;
                    end else begin
                        m_ptr[k]++;
                    end
                end
            end
            1: begin
                m_left[k]--;
                if (m_left[k] == 0) m_phase[k] = 2;
            end
            default: m_phase[k] = 0;
        endcase
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            cmp_step(0);
            cmp_step(1);
        end
    end

    // read-back address walks every row continuously
    initial forever begin
        @(posedge clk);
        #1 rd_addr = rd_addr + 2'd1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_grid(input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] r2, input logic [3:0] r3);
        logic [3:0] rows [4];
        rows = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_row   = rows[i];
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Returns rising edges after the start edge until done was seen (-1 on timeout).
    task automatic wait_done(input string nm, output int g0, output int g1);
        int e;
        e = 0; g0 = -1; g1 = -1;
        while ((g0 < 0 || g1 < 0) && e < 60) begin
            @(negedge clk);
            if (done0 && g0 < 0) g0 = e;
            if (done1 && g1 < 0) g1 = e;
            tick();
            e++;
        end
        if (g0 < 0) chk({nm, "_timeout0"}, 0, 1);
        if (g1 < 0) chk({nm, "_timeout1"}, 0, 1);
        tick();
    endtask

    task automatic run(input string nm, output int g0, output int g1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nm, g0, g1);
    endtask

    initial begin
        int g0, g1;
        logic [3:0] exp_rows [4];
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_total", tot0, 0);
        chk("reset_busy", busy0, 0);
        tick();

        // full 4x4: only the corners go
        load_grid(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        run("t1", g0, g1);
        chk("t1_first", fst0, 4);
        chk("t1_total", tot0, 4);
        chk("t1_pass", pc0, 1);
        chk("t1_limit", lim0, 0);
        chk("t1_latency", g0, 2);
        exp_rows = '{4'b0110, 4'b1111, 4'b1111, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_rd_row", row0, exp_rows[rd_addr]);
        end
        tick();

        // 3x3 block: corners, then arms, then centre
        load_grid(4'b1110, 4'b1110, 4'b1110, 4'b0000);
        run("t2", g0, g1);
        chk("t2_first", fst0, 4);
        chk("t2_total", tot0, 9);
        chk("t2_pass", pc0, 3);
        chk("t2_latency", g0, 4);
        chk("t3_total", tot1, 8);
        chk("t3_pass", pc1, 2);
        chk("t3_limit", lim1, 1);
        chk("t3_latency", g1, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_addr == 2'd1) chk("t3_rd_row1", row1, 4'b0100);
        end
        tick();

        // the limited instance still holds the centre cell; re-run the swept grid
        run("t3b", g0, g1);
        chk("t3b_total_lim", tot1, 1);
        chk("t3b_total_main", tot0, 0);

        // empty grid
        load_grid(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        run("t4", g0, g1);
        chk("t4_latency", g0, 1);
        chk("t4_total", tot0, 0);
        chk("t4_pass", pc0, 0);

        // start and a row in the same cycle: the row is dropped
        load_valid = 1'b1;
        load_row   = 4'b1111;
        start      = 1'b1;
        @(negedge clk);
        chk("t6_load_ready", lr0, 0);
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy0, 1);
        wait_done("t6", g0, g1);
        chk("t6_total", tot0, 0);

        // reset in the middle of pass 2
        load_grid(4'b1110, 4'b1110, 4'b1110, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy0, 0);
        chk("t5_total", tot0, 0);
        chk("t5_row", row0, 0);
        tick();
        rst = 1'b0;
        tick();

        // partial reload: start must be ignored
        load_grid(4'b1110, 4'b1110, 4'b1110, 4'b0000);
        // only three rows are needed to exercise the not-loaded case; the fourth
        // was accepted above, so reset again and reload three
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_row   = 4'b1110;
            tick();
        end
        load_valid = 1'b0;
        start = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("t5_start_ignored", busy0, 0);
        start = 1'b0;
        tick();
        load_valid = 1'b1;
        load_row   = 4'b0000;
        tick();
        load_valid = 1'b0;
        run("t5b", g0, g1);
        chk("t5b_total", tot0, 9);
        chk("t5b_pass", pc0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
